ddr3_cmd_arbiter: RTL and testbench
===================================

# ddr3_cmd_arbiter

Multi-port front end for the DDR3 controller. It arbitrates up to four host requesters and serialises their commands into the 33-bit command FIFO. It also streams write data into the 16-bit input data FIFO. It sits between host-side requesters and the controller's FIFO write ports, replacing a single direct cmd/addr/din host port.

## Interface
- NREQ, 4: number of requesters, legal 2..4
- DATA_DEPTH, 32: input data FIFO depth, used for block-write space check
- BLK_LEN, 8: words per block write, equal to burst length

Ports:
- clk  in  1  controller clock
- reset  in  1  synchronous, active-high
- ready  in  1  DDR3 init complete; no grants while low
- req  in  NREQ  per-requester request, held until granted
- req_cmd  in  3*NREQ  per-requester command; slice i is [3i+2:3i]
- req_addr  in  25*NREQ  per-requester address, slice i is [25i+24:25i]
- req_din  in  16*NREQ  per-requester write data, slice i is [16i+15:16i]
- cmd_notfull  in  1  command FIFO not full
- data_notfull  in  1  data FIFO not full
- data_fillcount  in  6  data FIFO occupancy
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- wack  out  NREQ  one-hot block-write beat acknowledge
- cmd_put  out  1  command FIFO write strobe
- cmd_data  out  33  {cmd[2:0], addr[24:0], 3'b000, id[1:0]}
- data_put  out  1  data FIFO write strobe
- data_out  out  16  data FIFO write word
- busy  out  1  state != IDLE

## Operation
- Command codes:
  - 000 NOP
  - 001 SCR (scalar read)
  - 010 SCW (scalar write)
  - 011 BLR (block read)
  - 100 BLW (block write)
  - 101..111 illegal
- States: IDLE, ISSUE, BURST.
- IDLE → ISSUE at the edge where all of the following hold:
  - ready=1 and cmd_notfull=1;
  - at least one eligible req;
  - the winner's space check passes: SCW needs data_notfull=1; BLW needs data_fillcount ≤ DATA_DEPTH−BLK_LEN; reads need no data space.
- Winner selection: round-robin. After granting requester i, priority order starts at (i+1) mod NREQ. The pointer resets to 0.
- A requester whose space check fails is skipped that cycle. The next eligible requester in priority order wins; no head-of-line blocking.
- At the decision edge, the block registers:
  - gnt[i]=1;
  - cmd_put=1 and cmd_data with id=i;
  - for SCW/BLW: data_put=1 and data_out=req_din slice i (word 0).
- NOP and illegal codes: the requester is still granted (gnt pulse), but cmd_put=0 and data_put=0.
- ISSUE lasts 1 cycle. It then goes to BURST if cmd=BLW, else IDLE.
- BURST lasts BLK_LEN−1 cycles:
  - wack[i]=1 every cycle;
  - req_din is captured at each edge, giving data_put=1 the following cycle for words 1..BLK_LEN−1;
  - a beat counter counts 0..BLK_LEN−2, then the block returns to IDLE.
- Requester rule: drop or replace req/cmd/addr after the gnt cycle. Advance req_din on every edge where gnt[i] or wack[i] is high.
- ready deasserting mid-burst does not abort the burst; it only blocks new grants.
- Full FIFO mid-burst cannot occur because space was reserved at grant.

## Timing
- Reset values:
  - gnt=0, wack=0, cmd_put=0, cmd_data=0, data_put=0, data_out=0, busy=0;
  - state=IDLE, RR pointer=0.
- Reset mid-burst: immediate return to IDLE and no further puts. The FIFOs are reset by the same system reset.
- Grant latency: req sampled at edge k, so gnt, cmd_put and word 0 are visible in cycle k+1.
- Minimum spacing: 2 cycles per non-BLW command (IDLE+ISSUE); BLK_LEN+1 cycles per BLW.
- BLW data_put timing: cycles k+1 (word 0) and k+3..k+BLK_LEN+1 (words 1..7). There is no put in cycle k+2.
- All outputs registered except wack and busy, which are decoded from state.

## Configuration
- DDR3_ARB_RR_EN
  - Defined: round-robin as above.
  - Undefined: fixed priority, lowest eligible index always wins, and the RR pointer logic is removed.
  - All other behaviour is identical.

## Test plan
- Reset then single SCW: ready=1, req[0] with cmd=010, addr=0x0001234, din=0xBEEF. Required: gnt=0001 and cmd_put one cycle later, cmd_data={010,0x0001234,000,00}, data_out=0xBEEF, then one idle cycle.
- RR fairness (macro defined): all four requesters continuously issue SCR. Required: grant order 0,1,2,3,0, spaced 2 cycles. With the macro undefined: all grants go to requester 0.
- BLW streaming: requester 2 issues cmd=100 with din sequence 0x0000..0x0007. Required: 8 data_put with values 0..7, wack=0100 for 7 cycles, busy high for 8 cycles, no grant to others meanwhile.
- Space check skip: data_fillcount=25, req[0]=BLW, req[1]=SCR. Required: requester 1 granted, requester 0 waits. Lowering fillcount to 24 → requester 0 granted next.
- Back-pressure and ready: cmd_notfull=0 or ready=0 with req pending → no gnt. Restoring both → gnt in the following cycle.
- Illegal/NOP and reset mid-burst: cmd=111 → gnt pulse with cmd_put=0. Reset asserted in the 3rd BURST cycle → next cycle all outputs 0, busy=0.

Source files
------------

// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: arbitrates up to four host requesters onto the DDR3
// command FIFO (33-bit entries) and streams their write data into the
// 16-bit input data FIFO. Block writes reserve data FIFO space at grant
// time and then stream BLK_LEN-1 further words with a per-beat acknowledge.
// Optional build macro DDR3_ARB_RR_EN: defined selects round-robin
// arbitration; undefined selects fixed priority (lowest index wins).
module ddr3_cmd_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_DEPTH = 32,
  parameter int BLK_LEN    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   req_cmd,
  input  logic [25*NREQ-1:0]  req_addr,
  input  logic [16*NREQ-1:0]  req_din,
  input  logic                cmd_notfull,
  input  logic                data_notfull,
  input  logic [5:0]          data_fillcount,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     wack,
  output logic                cmd_put,
  output logic [32:0]         cmd_data,
  output logic                data_put,
  output logic [15:0]         data_out,
  output logic                busy
);

  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;
  localparam logic [2:0] CMD_BLR = 3'b011;
  localparam logic [2:0] CMD_BLW = 3'b100;
  localparam int         BEAT_W  = (BLK_LEN > 2) ? $clog2(BLK_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t              r_state;
  logic [1:0]          r_id;
  logic                r_is_blw;
  logic [BEAT_W-1:0]   r_beat;
  logic [NREQ-1:0]     r_gnt;
  logic                r_cmd_put;
  logic [32:0]         r_cmd_data;
  logic                r_data_put;
  logic [15:0]         r_data_out;

  logic [1:0]          w_base;
  logic [1:0]          w_win;
  logic                w_found;
  logic                w_go;
  logic [2:0]          w_cmd;
  logic [24:0]         w_addr;
  logic [15:0]         w_din;
  logic [15:0]         w_burst_din;
  logic                w_legal;
  logic                w_has_data;

  // Data FIFO space a command needs before it may be granted.
  function automatic logic space_ok(input logic [2:0] cmd, input logic dnf,
                                    input logic [5:0] fill);
    case (cmd)
      CMD_SCW: return dnf;
      CMD_BLW: return ({26'd0, fill} <= 32'(DATA_DEPTH - BLK_LEN));
      default: return 1'b1;
    endcase
  endfunction

`ifdef DDR3_ARB_RR_EN
  logic [1:0] r_ptr;
  assign w_base = r_ptr;
`else
  assign w_base = 2'd0;
`endif

  // Pick the first eligible requester in priority order starting at w_base;
  // requesters failing their space check are skipped.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(w_base) + k) % NREQ;
      if (req[idx] && space_ok(req_cmd[3*idx +: 3], data_notfull, data_fillcount)) begin
        w_found = 1'b1;
        w_win   = 2'(idx);
      end
    end
  end

  assign w_go        = ready & cmd_notfull & w_found;
  assign w_cmd       = req_cmd[3*int'(w_win) +: 3];
  assign w_addr      = req_addr[25*int'(w_win) +: 25];
  assign w_din       = req_din[16*int'(w_win) +: 16];
  assign w_burst_din = req_din[16*int'(r_id) +: 16];
  assign w_legal     = (w_cmd == CMD_SCR) || (w_cmd == CMD_SCW) ||
                       (w_cmd == CMD_BLR) || (w_cmd == CMD_BLW);
  assign w_has_data  = (w_cmd == CMD_SCW) || (w_cmd == CMD_BLW);

  // Arbitration FSM with registered grant, command and data strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_id       <= 2'd0;
      r_is_blw   <= 1'b0;
      r_beat     <= '0;
      r_gnt      <= '0;
      r_cmd_put  <= 1'b0;
      r_cmd_data <= '0;
      r_data_put <= 1'b0;
      r_data_out <= '0;
`ifdef DDR3_ARB_RR_EN
      r_ptr      <= 2'd0;
`endif
    end else begin
      r_gnt      <= '0;
      r_cmd_put  <= 1'b0;
      r_data_put <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state  <= ISSUE;
            r_id     <= w_win;
            r_is_blw <= (w_cmd == CMD_BLW);
            r_gnt    <= NREQ'(1) << w_win;
            if (w_legal) begin
              r_cmd_put  <= 1'b1;
              r_cmd_data <= {w_cmd, w_addr, 3'b000, w_win};
            end
            if (w_has_data) begin
              r_data_put <= 1'b1;
              r_data_out <= w_din;
            end
`ifdef DDR3_ARB_RR_EN
            r_ptr <= (int'(w_win) + 1 == NREQ) ? 2'd0 : w_win + 2'd1;
`endif
          end
        end
        ISSUE: begin
          r_beat  <= '0;
          r_state <= r_is_blw ? BURST : IDLE;
        end
        BURST: begin
          r_data_put <= 1'b1;
          r_data_out <= w_burst_din;
          if (r_beat == BEAT_W'(BLK_LEN - 2)) begin
            r_state <= IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign cmd_put  = r_cmd_put;
  assign cmd_data = r_cmd_data;
  assign data_put = r_data_put;
  assign data_out = r_data_out;
  assign wack     = (r_state == BURST) ? (NREQ'(1) << r_id) : '0;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Testbench for ddr3_cmd_arbiter: table-driven single commands plus
// hand-written sequences for fairness, block writes, space skipping,
// back-pressure and reset during a burst. Command and data FIFO writes are
// checked against scoreboard queues filled when stimulus is driven.
module tb_ddr3_cmd_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ready;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_cmd;
  logic [25*NREQ-1:0] req_addr;
  logic [16*NREQ-1:0] req_din;
  logic              cmd_notfull;
  logic              data_notfull;
  logic [5:0]        data_fillcount;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   wack;
  logic              cmd_put;
  logic [32:0]       cmd_data;
  logic              data_put;
  logic [15:0]       data_out;
  logic              busy;

  ddr3_cmd_arbiter #(.NREQ(NREQ), .DATA_DEPTH(32), .BLK_LEN(8)) dut (
    .clk(clk), .reset(reset), .ready(ready), .req(req), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_din(req_din), .cmd_notfull(cmd_notfull),
    .data_notfull(data_notfull), .data_fillcount(data_fillcount),
    .gnt(gnt), .wack(wack), .cmd_put(cmd_put), .cmd_data(cmd_data),
    .data_put(data_put), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] cmd_q[$];
  logic [15:0] data_q[$];

  typedef struct {
    int         id;
    logic [2:0] cmd;
    logic [24:0] addr;
    logic [15:0] din;
    logic [3:0] exp_gnt;
    logic       exp_cput;
    logic       exp_dput;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] mk_cmd(input logic [2:0] c, input logic [24:0] a, input int id);
    return {c, a, 3'b000, 2'(id)};
  endfunction

  // One clock; then score any FIFO write the DUT made on that edge.
  task automatic tick();
    logic [32:0] ec;
    logic [15:0] ed;
    @(posedge clk);
    #1;
    if (cmd_put) begin
      if (cmd_q.size() == 0) chk("cmd_put_unexpected", 64'(cmd_put), 64'(0));
      else begin ec = cmd_q.pop_front(); chk("cmd_data", 64'(cmd_data), 64'(ec)); end
    end
    if (data_put) begin
      if (data_q.size() == 0) chk("data_put_unexpected", 64'(data_put), 64'(0));
      else begin ed = data_q.pop_front(); chk("data_out", 64'(data_out), 64'(ed)); end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [2:0] c, input logic [24:0] a, input logic [15:0] d);
    req_cmd[3*id +: 3]   = c;
    req_addr[25*id +: 25] = a;
    req_din[16*id +: 16] = d;
  endtask

  initial begin
    logic [15:0] w;
    logic        adv;
    int          order[5];

    reset = 1'b1; ready = 1'b0; req = '0; req_cmd = '0; req_addr = '0; req_din = '0;
    cmd_notfull = 1'b1; data_notfull = 1'b1; data_fillcount = 6'd0;

    vecs[0] = '{0, 3'b010, 25'h0001234, 16'hBEEF, 4'b0001, 1'b1, 1'b1};
    vecs[1] = '{1, 3'b001, 25'h1ABCDEF, 16'h1111, 4'b0010, 1'b1, 1'b0};
    vecs[2] = '{3, 3'b011, 25'h0000040, 16'h2222, 4'b1000, 1'b1, 1'b0};
    vecs[3] = '{2, 3'b000, 25'h0000055, 16'h3333, 4'b0100, 1'b0, 1'b0};
    vecs[4] = '{1, 3'b111, 25'h00000AA, 16'h4444, 4'b0010, 1'b0, 1'b0};
    vecs[5] = '{3, 3'b010, 25'h1FFFFFF, 16'h8001, 4'b1000, 1'b1, 1'b1};
    vecs[6] = '{0, 3'b101, 25'h0000123, 16'h5555, 4'b0001, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_wack", 64'(wack), 0);
    chk("rst_cmd_put", 64'(cmd_put), 0);
    chk("rst_cmd_data", 64'(cmd_data), 0);
    chk("rst_data_put", 64'(data_put), 0);
    chk("rst_data_out", 64'(data_out), 0);
    chk("rst_busy", 64'(busy), 0);
    ready = 1'b1;
    tick();

    // Table-driven single commands from IDLE
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].id, vecs[i].cmd, vecs[i].addr, vecs[i].din);
      req = 4'(1) << vecs[i].id;
      if (vecs[i].exp_cput) cmd_q.push_back(mk_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].id));
      if (vecs[i].exp_dput) data_q.push_back(vecs[i].din);
      tick();
      chk("vec_gnt", 64'(gnt), 64'(vecs[i].exp_gnt));
      chk("vec_cmd_put", 64'(cmd_put), 64'(vecs[i].exp_cput));
      chk("vec_data_put", 64'(data_put), 64'(vecs[i].exp_dput));
      chk("vec_busy", 64'(busy), 1);
      req = '0;
      tick();
      chk("vec_idle_gnt", 64'(gnt), 0);
      chk("vec_idle_busy", 64'(busy), 0);
    end

    // Fairness: four requesters continuously issuing SCR
    do_reset();
`ifdef DDR3_ARB_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 25'(32'h100 + i), 16'h0);
    for (int i = 0; i < 5; i++) cmd_q.push_back(mk_cmd(3'b001, 25'(32'h100 + order[i]), order[i]));
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c % 2 == 0) chk("rr_gnt", 64'(gnt), 64'(4'(1) << order[c/2]));
      else            chk("rr_gap", 64'(gnt), 0);
    end
    req = '0;
    tick();
    chk("rr_stop", 64'(gnt), 0);

    // Block write from requester 2, with requester 1 arriving mid-burst
    do_reset();
    w = 16'h0000;
    set_req(2, 3'b100, 25'h0ABCDE, w);
    set_req(1, 3'b001, 25'h0000777, 16'h0);
    cmd_q.push_back(mk_cmd(3'b100, 25'h0ABCDE, 2));
    for (int i = 0; i < 8; i++) data_q.push_back(16'(i));
    cmd_q.push_back(mk_cmd(3'b001, 25'h0000777, 1));
    req = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      adv = gnt[2] | wack[2];
      tick();
      if (adv) begin w = w + 16'd1; req_din[32 +: 16] = w; end
      chk("blw_gnt", 64'(gnt), (c == 1) ? 64'(4'b0100) : (c == 10) ? 64'(4'b0010) : 64'(0));
      chk("blw_wack", 64'(wack), (c >= 2 && c <= 8) ? 64'(4'b0100) : 64'(0));
      chk("blw_busy", 64'(busy), (c <= 8 || c == 10) ? 64'(1) : 64'(0));
      chk("blw_data_put", 64'(data_put), (c == 1 || (c >= 3 && c <= 9)) ? 64'(1) : 64'(0));
      if (c == 1) req = 4'b0000;
      if (c == 2) req = 4'b0010;
      if (c == 10) req = 4'b0000;
    end

    // Space check skip: BLW blocked by fill level, SCR passes it
    data_fillcount = 6'd25;
    set_req(0, 3'b100, 25'h0000100, 16'h5A5A);
    set_req(1, 3'b001, 25'h0000200, 16'h0);
    cmd_q.push_back(mk_cmd(3'b001, 25'h0000200, 1));
    cmd_q.push_back(mk_cmd(3'b100, 25'h0000100, 0));
    for (int i = 0; i < 8; i++) data_q.push_back(16'h5A5A);
    req = 4'b0011;
    tick();
    chk("skip_gnt1", 64'(gnt), 64'(4'b0010));
    req = 4'b0001;
    tick();
    chk("skip_wait", 64'(gnt), 0);
    tick();
    chk("skip_still", 64'(gnt), 0);
    data_fillcount = 6'd24;
    tick();
    chk("skip_gnt0", 64'(gnt), 64'(4'b0001));
    req = '0;
    for (int c = 0; c < 9; c++) tick();
    chk("skip_done_busy", 64'(busy), 0);
    data_fillcount = 6'd0;

    // Back-pressure and ready gating
    set_req(3, 3'b001, 25'h0000333, 16'h0);
    req = 4'b1000;
    cmd_notfull = 1'b0;
    for (int c = 0; c < 3; c++) begin tick(); chk("bp_cmdfull", 64'(gnt), 0); end
    cmd_notfull = 1'b1;
    ready = 1'b0;
    for (int c = 0; c < 2; c++) begin tick(); chk("bp_notready", 64'(gnt), 0); end
    ready = 1'b1;
    cmd_q.push_back(mk_cmd(3'b001, 25'h0000333, 3));
    tick();
    chk("bp_restore", 64'(gnt), 64'(4'b1000));
    req = '0;
    tick();

    // Reset in the third burst cycle
    set_req(0, 3'b100, 25'h0000999, 16'h1111);
    cmd_q.push_back(mk_cmd(3'b100, 25'h0000999, 0));
    for (int i = 0; i < 3; i++) data_q.push_back(16'h1111);
    req = 4'b0001;
    tick();
    chk("mr_gnt", 64'(gnt), 64'(4'b0001));
    req = '0;
    tick();
    tick();
    tick();
    chk("mr_wack", 64'(wack), 64'(4'b0001));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_gnt0", 64'(gnt), 0);
    chk("mr_wack0", 64'(wack), 0);
    chk("mr_cmd_put0", 64'(cmd_put), 0);
    chk("mr_cmd_data0", 64'(cmd_data), 0);
    chk("mr_data_put0", 64'(data_put), 0);
    chk("mr_data_out0", 64'(data_out), 0);
    chk("mr_busy0", 64'(busy), 0);
    tick();
    chk("mr_after_busy", 64'(busy), 0);

    chk("cmd_q_left", 64'(cmd_q.size()), 0);
    chk("data_q_left", 64'(data_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
